// File: rtl/als_pkg.sv
// Shared definitions for als_stats: FSM states, width derivations and the saturating mean.
package als_pkg;

   typedef enum logic [1:0] {
      WAIT_SOF,
      ACCUM,
      SKIP,
      PUBLISH
   } als_state_e;

   function automatic int unsigned acc_bits_f(input int unsigned pb, input int unsigned mc,
                                              input int unsigned mr);
      return pb + $clog2(mc) + $clog2(mr);
   endfunction

   function automatic int unsigned npix_bits_f(input int unsigned mc, input int unsigned mr);
      return $clog2(mc) + $clog2(mr) + 1;
   endfunction

   // Mean clamps to all-ones when sum >> sh does not fit in pbits.
   function automatic logic [63:0] sat_shift(input logic [63:0] sum, input logic [5:0] sh,
                                             input int unsigned pbits);
      logic [63:0] shifted;
      logic [63:0] lim;
      shifted = sum >> sh;
      lim     = (64'd1 << pbits) - 64'd1;
      return (shifted > lim) ? lim : shifted;
   endfunction

endpackage

// File: rtl/als_chan_acc.sv
// One CFA channel: running sum (plus min/max when ALS_MINMAX_EN is defined) and the
// published snapshot of it. Clear and add may coincide: the added pixel starts the new frame.
module als_chan_acc
   import als_pkg::*;
#(
   parameter int unsigned PIXEL_BITS = 10,
   parameter int unsigned ACC_BITS   = 34
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clr,
   input  logic                  add,
   input  logic [PIXEL_BITS-1:0] data,
   input  logic                  snap,
   input  logic [5:0]            avg_shift,
   output logic [ACC_BITS-1:0]   snap_sum,
   output logic [PIXEL_BITS-1:0] snap_mean
`ifdef ALS_MINMAX_EN
  ,output logic [PIXEL_BITS-1:0] snap_min,
   output logic [PIXEL_BITS-1:0] snap_max
`endif
);

   logic [ACC_BITS-1:0]   sum_q, sum_d, snap_sum_q, snap_sum_d;
   logic [PIXEL_BITS-1:0] snap_mean_q, snap_mean_d;

   always_comb begin
      sum_d = clr ? '0 : sum_q;
      if (add) begin
         sum_d = sum_d + ACC_BITS'(data);
      end
      snap_sum_d  = snap ? sum_q : snap_sum_q;
      snap_mean_d = snap ? PIXEL_BITS'(sat_shift(64'(sum_q), avg_shift, PIXEL_BITS)) : snap_mean_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sum_q       <= '0;
         snap_sum_q  <= '0;
         snap_mean_q <= '0;
      end else begin
         sum_q       <= sum_d;
         snap_sum_q  <= snap_sum_d;
         snap_mean_q <= snap_mean_d;
      end
   end

   assign snap_sum  = snap_sum_q;
   assign snap_mean = snap_mean_q;

`ifdef ALS_MINMAX_EN
   logic [PIXEL_BITS-1:0] min_q, min_d, max_q, max_d;
   logic [PIXEL_BITS-1:0] snap_min_q, snap_min_d, snap_max_q, snap_max_d;

   always_comb begin
      min_d = clr ? '1 : min_q;
      max_d = clr ? '0 : max_q;
      if (add) begin
         if (data < min_d) min_d = data;
         if (data > max_d) max_d = data;
      end
      snap_min_d = snap ? min_q : snap_min_q;
      snap_max_d = snap ? max_q : snap_max_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         min_q      <= '1;
         max_q      <= '0;
         snap_min_q <= '0;
         snap_max_q <= '0;
      end else begin
         min_q      <= min_d;
         max_q      <= max_d;
         snap_min_q <= snap_min_d;
         snap_max_q <= snap_max_d;
      end
   end

   assign snap_min = snap_min_q;
   assign snap_max = snap_max_q;
`endif

endmodule

// File: rtl/als_stats.sv
// als_stats: ROI-cropped per-CFA-channel frame statistics with decimation and overrun count.
// Define ALS_MINMAX_EN to add per-channel stats_min/stats_max outputs.
module als_stats
   import als_pkg::*;
#(
   parameter  int unsigned PIXEL_BITS = 10,
   parameter  int unsigned MAX_COLS   = 4096,
   parameter  int unsigned MAX_ROWS   = 4096,
   parameter  int unsigned CFA_W      = 2,
   parameter  int unsigned CFA_H      = 2,
   localparam int unsigned CW         = $clog2(MAX_COLS),
   localparam int unsigned RW         = $clog2(MAX_ROWS),
   localparam int unsigned NUM_CH     = CFA_W * CFA_H,
   localparam int unsigned ACC_BITS   = acc_bits_f(PIXEL_BITS, MAX_COLS, MAX_ROWS),
   localparam int unsigned NPIX_BITS  = npix_bits_f(MAX_COLS, MAX_ROWS)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [CW-1:0]                  cfg_trim_left,
   input  logic [CW:0]                    cfg_width,
   input  logic [RW-1:0]                  cfg_trim_top,
   input  logic [RW:0]                    cfg_height,
   input  logic [5:0]                     cfg_avg_shift,
   input  logic [3:0]                     cfg_skip,
   input  logic                           i_fv,
   input  logic                           i_lv,
   input  logic [PIXEL_BITS-1:0]          i_data,
   output logic                           stats_valid,
   input  logic                           stats_ready,
   output logic [NUM_CH*ACC_BITS-1:0]     stats_sum,
   output logic [NUM_CH*PIXEL_BITS-1:0]   stats_mean,
   output logic [NPIX_BITS-1:0]           stats_npix,
   output logic [31:0]                    stats_frame,
   output logic [7:0]                     overrun_cnt
`ifdef ALS_MINMAX_EN
  ,output logic [NUM_CH*PIXEL_BITS-1:0]   stats_min,
   output logic [NUM_CH*PIXEL_BITS-1:0]   stats_max
`endif
);

   localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic                  fv_r_q, fv_r_d, fv_rr_q, fv_rr_d, lv_r_q, lv_r_d, lv_p_q, lv_p_d;
   logic [PIXEL_BITS-1:0] data_r_q, data_r_d, pd_q, pd_d;
   logic [CW-1:0]         col_q, col_d, left_q, left_d;
   logic [RW-1:0]         row_q, row_d, top_q, top_d;
   logic [CW:0]           width_q, width_d, col_x, left_x;
   logic [RW:0]           height_q, height_d, row_x, top_x;
   logic [5:0]            shift_q, shift_d, pub_shift_q, pub_shift_d;
   logic [3:0]            skip_cfg_q, skip_cfg_d, skip_q, skip_d;
   logic                  pv_q, pv_d, sof_q, sof_d, eof_q, eof_d;
   logic [CHW-1:0]        ch_q, ch_d;
   als_state_e            state_q, state_d;
   logic [NPIX_BITS-1:0]  npix_q, npix_d, snap_npix_q, snap_npix_d;
   logic [31:0]           frame_q, frame_d, snap_frame_q, snap_frame_d;
   logic                  valid_q, valid_d;
   logic [7:0]            ovr_q, ovr_d;
   logic                  lv_eff, sof, eof, eol, in_roi, acc_on, add_en, publish;
   int unsigned           ch_i;

   // Stage 1 registers the inputs; stage 2 carries ROI/channel decisions alongside SOF/EOF.
   always_comb begin
      fv_r_d   = i_fv;
      lv_r_d   = i_lv;
      data_r_d = i_data;
      fv_rr_d  = fv_r_q;
      lv_eff   = fv_r_q & lv_r_q;
      lv_p_d   = lv_eff;
      sof      = fv_r_q & ~fv_rr_q;
      eof      = ~fv_r_q & fv_rr_q;
      eol      = lv_p_q & ~lv_eff;
      col_d    = lv_eff ? col_q + CW'(1) : '0;
      row_d    = ~fv_r_q ? '0 : (eol ? row_q + RW'(1) : row_q);

      left_d     = sof ? cfg_trim_left : left_q;
      width_d    = sof ? cfg_width     : width_q;
      top_d      = sof ? cfg_trim_top  : top_q;
      height_d   = sof ? cfg_height    : height_q;
      shift_d    = sof ? cfg_avg_shift : shift_q;
      skip_cfg_d = sof ? cfg_skip      : skip_cfg_q;

      col_x  = {1'b0, col_q};
      left_x = {1'b0, left_d};
      row_x  = {1'b0, row_q};
      top_x  = {1'b0, top_d};
      in_roi = (col_x >= left_x) && (col_x < left_x + width_d) &&
               (row_x >= top_x)  && (row_x < top_x + height_d);
      ch_i   = (CFA_H == 2 ? 32'(row_q[0]) : 32'd0) * CFA_W + (CFA_W == 2 ? 32'(col_q[0]) : 32'd0);
      ch_d   = ch_i[CHW-1:0];
      pv_d   = lv_eff & in_roi;
      pd_d   = data_r_q;
      sof_d  = sof;
      eof_d  = eof;
   end

   // PUBLISH also honours SOF: a frame may start in the very cycle the previous one publishes.
   always_comb begin
      state_d     = state_q;
      skip_d      = skip_q;
      pub_shift_d = pub_shift_q;
      acc_on      = 1'b0;
      publish     = 1'b0;
      case (state_q)
         WAIT_SOF, PUBLISH: begin
            publish = (state_q == PUBLISH);
            state_d = WAIT_SOF;
            if (sof_q) begin
               if (skip_q == '0) begin
                  state_d = ACCUM;
                  acc_on  = 1'b1;
               end else begin
                  state_d = SKIP;
               end
            end
         end
         ACCUM: begin
            acc_on = 1'b1;
            if (eof_q) begin
               state_d     = PUBLISH;
               skip_d      = skip_cfg_q;
               pub_shift_d = shift_q;
            end
         end
         SKIP: begin
            if (eof_q) begin
               state_d = WAIT_SOF;
               skip_d  = skip_q - 4'd1;
            end
         end
         default: state_d = WAIT_SOF;
      endcase

      add_en       = acc_on & pv_q;
      npix_d       = (publish ? '0 : npix_q) + NPIX_BITS'(add_en);
      frame_d      = publish ? frame_q + 32'd1 : frame_q;
      snap_npix_d  = publish ? npix_q : snap_npix_q;
      snap_frame_d = publish ? frame_q + 32'd1 : snap_frame_q;
      valid_d      = publish | (valid_q & ~stats_ready);
      ovr_d        = (publish & valid_q & ~stats_ready & (ovr_q != '1)) ? ovr_q + 8'd1 : ovr_q;
   end

   // fv history resets high so a frame already in flight at reset release never looks like SOF.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fv_r_q <= 1'b1;   fv_rr_q <= 1'b1;  lv_r_q <= 1'b0;   lv_p_q <= 1'b0;
         data_r_q <= '0;   pd_q <= '0;       col_q <= '0;      row_q <= '0;
         left_q <= '0;     width_q <= '0;    top_q <= '0;      height_q <= '0;
         shift_q <= '0;    skip_cfg_q <= '0; skip_q <= '0;     pub_shift_q <= '0;
         pv_q <= 1'b0;     sof_q <= 1'b0;    eof_q <= 1'b0;    ch_q <= '0;
         state_q <= WAIT_SOF;
         npix_q <= '0;     snap_npix_q <= '0; frame_q <= '0;   snap_frame_q <= '0;
         valid_q <= 1'b0;  ovr_q <= '0;
      end else begin
         fv_r_q <= fv_r_d;   fv_rr_q <= fv_rr_d;   lv_r_q <= lv_r_d;   lv_p_q <= lv_p_d;
         data_r_q <= data_r_d; pd_q <= pd_d;       col_q <= col_d;     row_q <= row_d;
         left_q <= left_d;   width_q <= width_d;   top_q <= top_d;     height_q <= height_d;
         shift_q <= shift_d; skip_cfg_q <= skip_cfg_d; skip_q <= skip_d; pub_shift_q <= pub_shift_d;
         pv_q <= pv_d;       sof_q <= sof_d;       eof_q <= eof_d;     ch_q <= ch_d;
         state_q <= state_d;
         npix_q <= npix_d;   snap_npix_q <= snap_npix_d; frame_q <= frame_d; snap_frame_q <= snap_frame_d;
         valid_q <= valid_d; ovr_q <= ovr_d;
      end
   end

   assign stats_valid = valid_q;
   assign stats_npix  = snap_npix_q;
   assign stats_frame = snap_frame_q;
   assign overrun_cnt = ovr_q;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      als_chan_acc #(
         .PIXEL_BITS(PIXEL_BITS),
         .ACC_BITS  (ACC_BITS)
      ) u_acc (
         .clk      (clk),
         .reset    (reset),
         .clr      (publish),
         .add      (add_en && (ch_q == CHW'(g))),
         .data     (pd_q),
         .snap     (publish),
         .avg_shift(pub_shift_q),
         .snap_sum (stats_sum[g*ACC_BITS +: ACC_BITS]),
         .snap_mean(stats_mean[g*PIXEL_BITS +: PIXEL_BITS])
`ifdef ALS_MINMAX_EN
        ,.snap_min (stats_min[g*PIXEL_BITS +: PIXEL_BITS]),
         .snap_max (stats_max[g*PIXEL_BITS +: PIXEL_BITS])
`endif
      );
   end

endmodule
